// File: rtl/m_run_ctrl_pkg.sv
// m_run_ctrl_pkg: shared state encoding and constants for the run controller.
`default_nettype none

package m_run_ctrl_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CLEAR = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Destination register whose write marks the end of a program.
  localparam logic [4:0] HALT_RD = 5'd30;

endpackage

`default_nettype wire

// File: rtl/m_run_counter.sv
// m_run_counter: 32-bit run-cycle counter with clear, enable and terminal-count flag.
`default_nettype none

module m_run_counter #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] count,
  output logic        tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

  // High during the last cycle the core may run before a forced stop.
  assign tc = (count == 32'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/m_run_ctrl.sv
// m_run_ctrl: loads a program into imem, clears the PC, runs the core and
// stops it on HALT (x30 write) or timeout.
`default_nettype none

module m_run_ctrl
  import m_run_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned AW         = 6,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input  logic          w_clock,
  input  logic          w_rst_n,
  input  logic          w_start,
  input  logic          w_ld_valid,
  input  logic [31:0]   w_ld_data,
  input  logic          w_ld_last,
  output logic          w_ld_ready,
  output logic          w_imem_we,
  output logic [AW-1:0] w_imem_addr,
  output logic [31:0]   w_imem_wd,
  output logic          w_pc_clr,
  output logic          w_run,
  input  logic          w_halt,
  output logic          w_done,
  output logic          w_timeout,
  output logic [31:0]   w_cycles
);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [AW-1:0] addr;
  logic          timeout_flag;
  logic          begin_load;
  logic          accept;
  logic          at_top;
  logic          load_end;
  logic          running;
  logic          cnt_tc;

  assign begin_load = ((state == S_IDLE) || (state == S_DONE)) && w_start;
  assign accept     = (state == S_LOAD) && w_ld_valid;
  assign at_top     = (addr == AW'(IMEM_DEPTH - 1));
  assign load_end   = accept && (w_ld_last || at_top);
  assign running    = (state == S_RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (w_start) state_nxt = S_LOAD;
      S_LOAD:  if (load_end) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_RUN;
      S_RUN:   if (w_halt || cnt_tc) state_nxt = S_DONE;
      S_DONE:  if (w_start) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state        <= S_IDLE;
      addr         <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      // The address saturates at the top word so a forced end never wraps to 0.
      if (begin_load) begin
        addr <= '0;
      end else if (accept && !at_top) begin
        addr <= addr + AW'(1);
      end
      // Halt takes priority over a timeout landing on the same cycle.
      if (begin_load) begin
        timeout_flag <= 1'b0;
      end else if (running && !w_halt && cnt_tc) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  m_run_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_cycles (
    .clk   (w_clock),
    .rst_n (w_rst_n),
    .clr   (begin_load),
    .en    (running),
    .count (w_cycles),
    .tc    (cnt_tc)
  );

  assign w_ld_ready  = (state == S_LOAD);
  assign w_imem_we   = accept;
  assign w_imem_addr = addr;
  assign w_imem_wd   = (state == S_LOAD) ? w_ld_data : 32'd0;
  assign w_pc_clr    = (state == S_CLEAR);
  assign w_run       = running;
  assign w_done      = (state == S_DONE);
  assign w_timeout   = timeout_flag;

endmodule

`default_nettype wire

// File: tb/tb_m_run_ctrl.sv
// tb_m_run_ctrl: randomized load/run transactions checked against a
// transaction-level model of the run controller.
`default_nettype none

module tb_m_run_ctrl;

  localparam int DEPTH = 64;
  localparam int AWID  = 6;
  localparam int TMO   = 16;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic            start    = 1'b0;
  logic            ld_valid = 1'b0;
  logic [31:0]     ld_data  = 32'd0;
  logic            ld_last  = 1'b0;
  logic            halt     = 1'b0;
  logic            ld_ready;
  logic            imem_we;
  logic [AWID-1:0] imem_addr;
  logic [31:0]     imem_wd;
  logic            pc_clr;
  logic            run;
  logic            done;
  logic            timeout;
  logic [31:0]     cycles;

  int n_cmp = 0;
  int n_err = 0;

  m_run_ctrl #(
    .IMEM_DEPTH (DEPTH),
    .AW         (AWID),
    .TIMEOUT    (TMO)
  ) dut (
    .w_clock     (clk),
    .w_rst_n     (rst_n),
    .w_start     (start),
    .w_ld_valid  (ld_valid),
    .w_ld_data   (ld_data),
    .w_ld_last   (ld_last),
    .w_ld_ready  (ld_ready),
    .w_imem_we   (imem_we),
    .w_imem_addr (imem_addr),
    .w_imem_wd   (imem_wd),
    .w_pc_clr    (pc_clr),
    .w_run       (run),
    .w_halt      (halt),
    .w_done      (done),
    .w_timeout   (timeout),
    .w_cycles    (cycles)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"},  32'(ld_ready),  32'd0);
    check_eq({tag, "_we"},     32'(imem_we),   32'd0);
    check_eq({tag, "_addr"},   32'(imem_addr), 32'd0);
    check_eq({tag, "_wd"},     imem_wd,        32'd0);
    check_eq({tag, "_pcclr"},  32'(pc_clr),    32'd0);
    check_eq({tag, "_run"},    32'(run),       32'd0);
    check_eq({tag, "_done"},   32'(done),      32'd0);
    check_eq({tag, "_tmo"},    32'(timeout),   32'd0);
    check_eq({tag, "_cycles"}, cycles,         32'd0);
  endtask

  // One program: start, load, clear, run, stop. halt_at outside 1..TMO means
  // the core never halts; reset_at > 0 pulls reset in that run cycle.
  task automatic run_program(input int n_words, input bit use_last, input int gap_pct,
                             input int halt_at, input int reset_at);
    int  accepted;
    int  guard;
    int  c;
    bit  ended;
    bit  exp_tmo;
    int  exp_cycles;

    exp_tmo    = !(halt_at >= 1 && halt_at <= TMO);
    exp_cycles = exp_tmo ? TMO : halt_at;

    @(negedge clk);
    start    = 1'b1;
    halt     = 1'($urandom % 2);
    ld_valid = 1'($urandom % 2);
    ld_last  = 1'b0;
    #1;
    check_eq("pre_start_ready", 32'(ld_ready), 32'd0);
    check_eq("pre_start_we",    32'(imem_we),  32'd0);
    @(negedge clk);

    accepted = 0;
    ended    = 1'b0;
    guard    = 0;
    while (!ended && guard < 1000) begin
      guard++;
      ld_valid = ($urandom_range(99) >= 32'(gap_pct));
      ld_data  = $urandom;
      ld_last  = use_last && ld_valid && (accepted == n_words - 1);
      start    = 1'($urandom % 2);
      halt     = 1'($urandom % 2);
      #1;
      check_eq("load_ready",  32'(ld_ready), 32'd1);
      check_eq("load_we",     32'(imem_we),  32'(ld_valid));
      check_eq("load_pcclr",  32'(pc_clr),   32'd0);
      check_eq("load_run",    32'(run),      32'd0);
      check_eq("load_done",   32'(done),     32'd0);
      check_eq("load_tmo",    32'(timeout),  32'd0);
      check_eq("load_cycles", cycles,        32'd0);
      if (ld_valid) begin
        check_eq("load_addr", 32'(imem_addr), 32'(accepted % DEPTH));
        check_eq("load_wd",   imem_wd,        ld_data);
        accepted++;
        ended = ld_last || (accepted == DEPTH);
      end
      @(negedge clk);
    end
    check_eq("load_ended", 32'(ended), 32'd1);

    ld_valid = 1'($urandom % 2);
    ld_last  = 1'b0;
    start    = 1'($urandom % 2);
    halt     = 1'($urandom % 2);
    #1;
    check_eq("clear_pcclr", 32'(pc_clr),   32'd1);
    check_eq("clear_run",   32'(run),      32'd0);
    check_eq("clear_ready", 32'(ld_ready), 32'd0);
    check_eq("clear_we",    32'(imem_we),  32'd0);
    @(negedge clk);

    c     = 0;
    ended = 1'b0;
    while (!ended && c < TMO + 4) begin
      c++;
      start    = 1'($urandom % 2);
      ld_valid = 1'($urandom % 2);
      halt     = (c == halt_at);
      if (c == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_rst");
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        halt  = 1'b0;
        return;
      end
      #1;
      check_eq("run_run",    32'(run),      32'd1);
      check_eq("run_pcclr",  32'(pc_clr),   32'd0);
      check_eq("run_done",   32'(done),     32'd0);
      check_eq("run_we",     32'(imem_we),  32'd0);
      check_eq("run_cycles", cycles,        32'(c - 1));
      ended = halt || (c == TMO);
      @(negedge clk);
    end

    start = 1'b0;
    repeat (3) begin
      halt     = 1'($urandom % 2);
      ld_valid = 1'($urandom % 2);
      #1;
      check_eq("done_done",   32'(done),     32'd1);
      check_eq("done_run",    32'(run),      32'd0);
      check_eq("done_ready",  32'(ld_ready), 32'd0);
      check_eq("done_cycles", cycles,        32'(exp_cycles));
      check_eq("done_tmo",    32'(timeout),  32'(exp_tmo));
      @(negedge clk);
    end
    halt     = 1'b0;
    ld_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ld_valid = 1'b1;
    halt     = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("idle_ready", 32'(ld_ready), 32'd0);
    check_eq("idle_we",    32'(imem_we),  32'd0);
    ld_valid = 1'b0;
    halt     = 1'b0;

    run_program(8,  1'b1, 0,  0,  5);
    run_program(6,  1'b1, 0,  7,  0);
    run_program(6,  1'b1, 0,  6,  0);
    run_program(10, 1'b1, 50, 9,  0);
    run_program(64, 1'b0, 0,  3,  0);
    run_program(4,  1'b1, 0,  0,  0);
    run_program(5,  1'b1, 0,  16, 0);
    run_program(1,  1'b1, 0,  1,  0);

    repeat (20) begin
      run_program(int'($urandom_range(1, 64)), 1'($urandom % 2),
                  int'($urandom_range(0, 60)), int'($urandom_range(0, 20)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
